// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job, beat, MAC and result signals for the MAC sequencer.
interface mac_seq_ctrl_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
);
    logic               start;
    logic [cnt_bw-1:0]  len;
    logic [psum_bw-1:0] psum_init;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [4*bw-1:0]    in_a;
    logic [4*bw-1:0]    in_b;
    logic [4*bw-1:0]    mac_a;
    logic [4*bw-1:0]    mac_b;
    logic [psum_bw-1:0] mac_c;
    logic [psum_bw-1:0] mac_out;
    logic               out_valid;
    logic               out_ready;
    logic [psum_bw-1:0] out_psum;
    modport master (
        output start, len, psum_init, in_valid, in_a, in_b, mac_out, out_ready,
        input  busy, in_ready, mac_a, mac_b, mac_c, out_valid, out_psum
    );
    modport slave (
        input  start, len, psum_init, in_valid, in_a, in_b, mac_out, out_ready,
        output busy, in_ready, mac_a, mac_b, mac_c, out_valid, out_psum
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job FSM and psum register that stream beats through an external 4-lane MAC.
module mac_seq_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
) (
    input logic            clk,
    input logic            reset,
    mac_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t             state_q, state_d;
    logic [psum_bw-1:0] psum_q, psum_d;
    logic [cnt_bw-1:0]  cnt_q, cnt_d;
    logic [cnt_bw-1:0]  len_q, len_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            psum_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            psum_q  <= psum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end
    always_comb begin
        state_d = state_q;
        psum_d  = psum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: if (bus.start) begin
                psum_d = bus.psum_init;
                if (bus.len != '0) begin
                    len_d   = bus.len;
                    cnt_d   = '0;
                    state_d = ACC;
                end else begin
                    state_d = DONE;
                end
            end
            ACC: if (bus.in_valid) begin
                psum_d = bus.mac_out;
                cnt_d  = cnt_q + cnt_bw'(1);
                if (cnt_q == len_q - cnt_bw'(1)) state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy      = state_q != IDLE;
    assign bus.in_ready  = state_q == ACC;
    assign bus.out_valid = state_q == DONE;
    assign bus.mac_a     = bus.in_ready ? bus.in_a : '0;
    assign bus.mac_b     = bus.in_ready ? bus.in_b : '0;
    assign bus.mac_c     = psum_q;
    assign bus.out_psum  = bus.out_valid ? psum_q : '0;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed checks of the MAC sequencer against a behavioural 4-lane MAC.
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    mac_seq_ctrl_if bus ();
    mac_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // unsigned activation times signed weight per lane, plus c, wrapping at 16 bits
    always_comb begin
        logic signed [15:0] s;
        s = bus.mac_c;
        for (int i = 0; i < 4; i++)
            s = s + 16'($signed({1'b0, bus.mac_a[i*4 +: 4]}) * $signed(bus.mac_b[i*4 +: 4]));
        bus.mac_out = s;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        logic [15:0] p;
        reset = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.psum_init = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_psum", 32'(bus.out_psum), 0);
        chk("rst_mac_c", 32'(bus.mac_c), 0);
        chk("rst_mac_a", 32'(bus.mac_a), 0);
        chk("rst_mac_b", 32'(bus.mac_b), 0);
        // len=1, 4x15 * 4x(-8)
        bus.start = 1'b1; bus.len = 8'd1; bus.psum_init = 16'd0;
        tick();
        bus.start = 1'b0;
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'h8888;
        #1;
        chk("t1_mac_a", 32'(bus.mac_a), 32'hFFFF);
        chk("t1_mac_b", 32'(bus.mac_b), 32'h8888);
        chk("t1_mac_c", 32'(bus.mac_c), 0);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_out_valid", 32'(bus.out_valid), 1);
        chk("t1_out_psum", 32'(bus.out_psum), 32'hFE20);
        chk("t1_in_ready_done", 32'(bus.in_ready), 0);
        chk("t1_mac_a_done", 32'(bus.mac_a), 0);
        // hold result with out_ready low, and pulse start while in DONE
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2); bus.len = 8'd2; bus.psum_init = 16'd7;
            tick();
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_psum", 32'(bus.out_psum), 32'hFE20);
        end
        // start during the DONE->IDLE handshake cycle is ignored too
        bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0; bus.out_ready = 1'b0;
        chk("hs_busy", 32'(bus.busy), 0);
        chk("hs_out_valid", 32'(bus.out_valid), 0);
        tick();
        chk("hs_still_idle", 32'(bus.busy), 0);
        // len=3, init=5, beats a=1,2,3 b=1 with two-cycle bubbles
        bus.start = 1'b1; bus.len = 8'd3; bus.psum_init = 16'd5;
        tick();
        bus.start = 1'b0;
        chk("t2_busy", 32'(bus.busy), 1);
        p = 16'd5;
        for (int k = 1; k <= 3; k++) begin
            bus.in_valid = 1'b1; bus.in_a = {4{4'(k)}}; bus.in_b = 16'h1111;
            #1;
            chk("t2_mac_c", 32'(bus.mac_c), 32'(p));
            p = p + 16'(4 * k);
            tick();
            bus.in_valid = 1'b0;
            if (k < 3) begin
                for (int j = 0; j < 2; j++) begin
                    chk("t2_bubble_psum", 32'(bus.mac_c), 32'(p));
                    chk("t2_bubble_valid", 32'(bus.out_valid), 0);
                    tick();
                end
            end
        end
        chk("t2_out_valid", 32'(bus.out_valid), 1);
        chk("t2_out_psum", 32'(bus.out_psum), 29);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_idle", 32'(bus.busy), 0);
        // len=0 goes straight to DONE with psum_init
        bus.start = 1'b1; bus.len = 8'd0; bus.psum_init = 16'd100;
        tick();
        bus.start = 1'b0;
        chk("t3_out_valid", 32'(bus.out_valid), 1);
        chk("t3_out_psum", 32'(bus.out_psum), 100);
        chk("t3_in_ready", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t3_in_ready_after", 32'(bus.in_ready), 0);
        chk("t3_idle", 32'(bus.busy), 0);
        // wrap: 32767 + 4 -> -32765
        bus.start = 1'b1; bus.len = 8'd1; bus.psum_init = 16'h7FFF;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 16'h1111; bus.in_b = 16'h1111;
        tick();
        bus.in_valid = 1'b0;
        chk("t4_out_psum", 32'(bus.out_psum), 32'h8003);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        // abort after 2 of 4 beats
        bus.start = 1'b1; bus.len = 8'd4; bus.psum_init = 16'd0;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 16'h1111; bus.in_b = 16'h1111;
        tick(); tick();
        bus.in_valid = 1'b0;
        chk("t5_psum_mid", 32'(bus.mac_c), 8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_psum", 32'(bus.mac_c), 0);
        chk("t5_out_valid", 32'(bus.out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_result", 32'(bus.out_valid), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
